// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the RX framer state encoding.
package eth_pkg;

  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
  localparam int         ETH_FCS_LEN       = 4;
  localparam int         ETH_MIN_FRAME_LEN = 64;
  // One byte beyond the FCS lets frame end release the last payload byte.
  localparam int         ETH_PIPE_DEPTH    = ETH_FCS_LEN + 1;

  typedef enum logic [1:0] {
    S_DROP,
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD
  } rx_framer_state_t;

endpackage

// File: rtl/eth_rx_delay_line.sv
// Five-byte shift register that holds back the FCS so only payload leaves the framer.
module eth_rx_delay_line
  import eth_pkg::*;
(
  input  logic       aclk,
  input  logic       areset,
  input  logic       shift,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] oldest,
  output logic       full,
  output logic [2:0] count
);

  logic [ETH_PIPE_DEPTH-1:0][7:0] pipe;

  // Flush wins over shift so a frame boundary always leaves the line empty.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pipe  <= '0;
      count <= '0;
    end else if (flush) begin
      pipe  <= '0;
      count <= '0;
    end else if (shift) begin
      pipe <= {pipe[ETH_PIPE_DEPTH-2:0], din};
      if (count != 3'(ETH_PIPE_DEPTH)) count <= count + 3'd1;
    end
  end

  assign oldest = pipe[ETH_PIPE_DEPTH-1];
  assign full   = (count == 3'(ETH_PIPE_DEPTH));

endmodule

// File: rtl/eth_rx_framer.sv
// GMII RX framer: preamble/SFD detect, FCS strip, AXI-Stream payload with error flag.
// Optional statistics counters are enabled by defining ETH_RX_FRAMER_STATS_EN.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_MIN  = 7,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        fcs_ok,
  output logic        preamble_sfd_valid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
`ifdef ETH_RX_FRAMER_STATS_EN
  ,
  output logic [31:0] stat_frames_ok,
  output logic [31:0] stat_frames_bad,
  output logic [31:0] stat_runts
`endif
);

  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  rx_framer_state_t state, state_nxt;
  logic [3:0]       pre_cnt, pre_cnt_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic             err, err_nxt;
  logic             sfd_nxt;

  logic             shift, flush;
  logic [7:0]       pipe_oldest;
  logic             pipe_full;
  logic [2:0]       pipe_cnt;

  logic             beat_vld, beat_last, beat_bad, runt_end;

  logic [7:0]       tdata_p0;
  logic             vld_p0, tlast_p0, tuser_p0, sfd_p0;

  eth_rx_delay_line u_delay (
    .aclk   (aclk),
    .areset (areset),
    .shift  (shift),
    .flush  (flush),
    .din    (gmii_rxd),
    .oldest (pipe_oldest),
    .full   (pipe_full),
    .count  (pipe_cnt)
  );

  always_comb begin
    state_nxt    = state;
    pre_cnt_nxt  = pre_cnt;
    byte_cnt_nxt = byte_cnt;
    err_nxt      = err;
    sfd_nxt      = 1'b0;
    shift        = 1'b0;
    flush        = 1'b0;
    beat_vld     = 1'b0;
    beat_last    = 1'b0;
    beat_bad     = 1'b0;
    runt_end     = 1'b0;

    unique case (state)
      S_DROP: begin
        flush = 1'b1;
        if (!gmii_rx_dv) state_nxt = S_IDLE;
      end

      S_IDLE: begin
        flush       = 1'b1;
        pre_cnt_nxt = 4'd0;
        if (gmii_rx_dv) begin
          if (gmii_rxd == ETH_PREAMBLE_BYTE) begin
            state_nxt   = S_PREAMBLE;
            pre_cnt_nxt = 4'd1;
          end else begin
            state_nxt = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        flush = 1'b1;
        if (!gmii_rx_dv) begin
          state_nxt   = S_IDLE;
          pre_cnt_nxt = 4'd0;
        end else if (gmii_rx_er) begin
          state_nxt = S_DROP;
        end else if (gmii_rxd == ETH_PREAMBLE_BYTE) begin
          pre_cnt_nxt = sat_inc4(pre_cnt);
        end else if ((gmii_rxd == ETH_SFD_BYTE) &&
                     ({28'd0, pre_cnt} >= 32'(PREAMBLE_MIN))) begin
          state_nxt    = S_PAYLOAD;
          sfd_nxt      = 1'b1;
          byte_cnt_nxt = '0;
          err_nxt      = 1'b0;
        end else begin
          state_nxt = S_DROP;
        end
      end

      S_PAYLOAD: begin
        if (!gmii_rx_dv) begin
          // Frame end: the oldest pipe byte is the last payload byte.
          flush     = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = S_IDLE;
          if (pipe_cnt < 3'(ETH_PIPE_DEPTH)) begin
            runt_end = 1'b1;
          end else begin
            beat_vld  = 1'b1;
            beat_last = 1'b1;
            beat_bad  = !fcs_ok || err ||
                        (byte_cnt < CNT_W'(ETH_MIN_FRAME_LEN));
          end
        end else if (byte_cnt == CNT_W'(MAX_FRAME_LEN)) begin
          flush     = 1'b1;
          err_nxt   = 1'b0;
          beat_vld  = 1'b1;
          beat_last = 1'b1;
          beat_bad  = 1'b1;
          state_nxt = S_DROP;
        end else begin
          shift        = 1'b1;
          byte_cnt_nxt = byte_cnt + CNT_W'(1);
          if (gmii_rx_er) err_nxt = 1'b1;
          if (pipe_full) beat_vld = 1'b1;
        end
      end

      default: state_nxt = S_DROP;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= S_DROP;
      pre_cnt  <= '0;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pre_cnt  <= pre_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      err      <= err_nxt;
    end
  end

  // Stage p0: registered AXI-Stream beat and SFD pulse
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tdata_p0 <= '0;
      vld_p0   <= 1'b0;
      tlast_p0 <= 1'b0;
      tuser_p0 <= 1'b0;
      sfd_p0   <= 1'b0;
    end else begin
      if (beat_vld) tdata_p0 <= pipe_oldest;
      vld_p0   <= beat_vld;
      tlast_p0 <= beat_last;
      tuser_p0 <= beat_bad;
      sfd_p0   <= sfd_nxt;
    end
  end

  assign m_axis_tdata       = tdata_p0;
  assign m_axis_tvalid      = vld_p0;
  assign m_axis_tlast       = tlast_p0;
  assign m_axis_tuser       = tuser_p0;
  assign preamble_sfd_valid = sfd_p0;

`ifdef ETH_RX_FRAMER_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_frames_ok  <= '0;
      stat_frames_bad <= '0;
      stat_runts      <= '0;
    end else begin
      if (beat_vld && beat_last && !beat_bad) stat_frames_ok  <= sat_inc32(stat_frames_ok);
      if (beat_vld && beat_last &&  beat_bad) stat_frames_bad <= sat_inc32(stat_frames_bad);
      if (runt_end) stat_runts <= sat_inc32(stat_runts);
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed, table-driven bench for eth_rx_framer; stats checks compile in with ETH_RX_FRAMER_STATS_EN.
module tb_eth_rx_framer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic        fcs_ok;
  logic        preamble_sfd_valid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
`ifdef ETH_RX_FRAMER_STATS_EN
  logic [31:0] stat_frames_ok, stat_frames_bad, stat_runts;
`endif

  eth_rx_framer #(.PREAMBLE_MIN(7), .MAX_FRAME_LEN(1518)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .gmii_rxd           (gmii_rxd),
    .gmii_rx_dv         (gmii_rx_dv),
    .gmii_rx_er         (gmii_rx_er),
    .fcs_ok             (fcs_ok),
    .preamble_sfd_valid (preamble_sfd_valid),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser)
`ifdef ETH_RX_FRAMER_STATS_EN
    ,
    .stat_frames_ok     (stat_frames_ok),
    .stat_frames_bad    (stat_frames_bad),
    .stat_runts         (stat_runts)
`endif
  );

  always #4 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Beat monitor state
  int cur_seed = 0;
  int beat_cnt, data_err, last_cnt, last_idx, last_user, pulse_cnt, pulse_err;
  int exp_ok = 0, exp_bad = 0, exp_runts = 0;

  function automatic logic [7:0] pat(input int k, input int s);
    return 8'((k * 7 + s) & 255);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    beat_cnt  = 0;
    data_err  = 0;
    last_cnt  = 0;
    last_idx  = -1;
    last_user = 0;
    pulse_cnt = 0;
    pulse_err = 0;
  endtask

  always @(negedge aclk) begin
    if (m_axis_tvalid) begin
      if (m_axis_tdata !== pat(beat_cnt, cur_seed)) data_err++;
      if (m_axis_tlast) begin
        last_cnt++;
        last_idx  = beat_cnt;
        last_user = int'(m_axis_tuser);
      end
      beat_cnt++;
    end
    if (preamble_sfd_valid) begin
      pulse_cnt++;
      if (gmii_rxd !== pat(0, cur_seed)) pulse_err++;
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
    cyc();
  endtask

  task automatic send_frame(input int npre, input logic [7:0] sfd, input int n,
                            input int er_at, input logic fok);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, sfd, 1'b0);
    for (int k = 0; k < n; k++) drive(1'b1, pat(k, cur_seed), (k == er_at));
    fcs_ok = fok;
    drive(1'b0, 8'h00, 1'b0);
    fcs_ok = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    int         npre;
    logic [7:0] sfd;
    int         nbytes;
    int         er_at;
    logic       fok;
    int         exp_beats;
    int         exp_last;
    int         exp_user;
    int         exp_pulse;
    int         exp_runt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{7,  8'hD5, 64, -1, 1'b1, 60, 1, 0, 1, 0};  // good frame
    vecs[1]  = '{7,  8'hD5, 64, -1, 1'b0, 60, 1, 1, 1, 0};  // FCS bad
    vecs[2]  = '{6,  8'hD5, 64, -1, 1'b1,  0, 0, 0, 0, 0};  // preamble too short
    vecs[3]  = '{7,  8'hD5, 64, -1, 1'b1, 60, 1, 0, 1, 0};  // recovers after short preamble
    vecs[4]  = '{7,  8'hD5,  3, -1, 1'b1,  0, 0, 0, 1, 1};  // runt
    vecs[5]  = '{7,  8'hD5, 40, -1, 1'b1, 36, 1, 1, 1, 0};  // undersize
    vecs[6]  = '{7,  8'hD5, 70, 20, 1'b1, 66, 1, 1, 1, 0};  // rx_er mid payload
    vecs[7]  = '{7,  8'hD5, 63, -1, 1'b1, 59, 1, 1, 1, 0};  // one byte below minimum
    vecs[8]  = '{7,  8'hD5,  5, -1, 1'b1,  1, 1, 1, 1, 0};  // smallest non-runt
    vecs[9]  = '{7,  8'hD5,  4, -1, 1'b1,  0, 0, 0, 1, 1};  // largest runt
    vecs[10] = '{20, 8'hD5, 65, -1, 1'b1, 61, 1, 0, 1, 0};  // long preamble, counter saturates
    vecs[11] = '{7,  8'hD4, 64, -1, 1'b1,  0, 0, 0, 0, 0};  // wrong SFD byte

    areset     = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_er = 1'b0;
    fcs_ok     = 1'b0;
    clear_mon();
    cyc();
    cyc();
    check("reset_tvalid", int'(m_axis_tvalid), 0);
    check("reset_tlast",  int'(m_axis_tlast), 0);
    check("reset_tuser",  int'(m_axis_tuser), 0);
    check("reset_tdata",  int'(m_axis_tdata), 0);
    check("reset_sfd",    int'(preamble_sfd_valid), 0);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);

    for (int v = 0; v < 12; v++) begin
      cur_seed = v * 13 + 1;
      clear_mon();
      send_frame(vecs[v].npre, vecs[v].sfd, vecs[v].nbytes, vecs[v].er_at, vecs[v].fok);
      check($sformatf("v%0d_beats", v),    beat_cnt,  vecs[v].exp_beats);
      check($sformatf("v%0d_data", v),     data_err,  0);
      check($sformatf("v%0d_tlast", v),    last_cnt,  vecs[v].exp_last);
      check($sformatf("v%0d_last_idx", v), last_idx,  vecs[v].exp_last ? vecs[v].exp_beats - 1 : -1);
      check($sformatf("v%0d_tuser", v),    last_user, vecs[v].exp_user);
      check($sformatf("v%0d_pulse", v),    pulse_cnt, vecs[v].exp_pulse);
      check($sformatf("v%0d_pulse_align", v), pulse_err, 0);
      if (vecs[v].exp_last != 0) begin
        if (vecs[v].exp_user != 0) exp_bad++;
        else exp_ok++;
      end
      exp_runts += vecs[v].exp_runt;
    end

    // Oversize: 1530 post-SFD bytes, cut off after 1518
    cur_seed = 200;
    clear_mon();
    send_frame(7, 8'hD5, 1530, -1, 1'b1);
    check("ovs_beats",    beat_cnt,  1514);
    check("ovs_data",     data_err,  0);
    check("ovs_tlast",    last_cnt,  1);
    check("ovs_last_idx", last_idx,  1513);
    check("ovs_tuser",    last_user, 1);
    exp_bad++;

    cur_seed = 201;
    clear_mon();
    send_frame(7, 8'hD5, 64, -1, 1'b1);
    check("post_ovs_beats", beat_cnt,  60);
    check("post_ovs_user",  last_user, 0);
    check("post_ovs_data",  data_err,  0);
    exp_ok++;

`ifdef ETH_RX_FRAMER_STATS_EN
    check("stat_ok",    int'(stat_frames_ok),  exp_ok);
    check("stat_bad",   int'(stat_frames_bad), exp_bad);
    check("stat_runts", int'(stat_runts),      exp_runts);
`endif

    // Reset asserted while payload is streaming
    cur_seed = 77;
    clear_mon();
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int k = 0; k < 30; k++) drive(1'b1, pat(k, cur_seed), 1'b0);
    check("mid_pre_reset_vld", int'(m_axis_tvalid), 1);
    check("mid_pre_reset_beats", beat_cnt, 24);
    areset = 1'b1;
    #1;
    check("mid_reset_tvalid", int'(m_axis_tvalid), 0);
    check("mid_reset_tdata",  int'(m_axis_tdata), 0);
    check("mid_reset_tlast",  int'(m_axis_tlast), 0);
    gmii_rxd = pat(30, cur_seed);
    cyc();
    areset = 1'b0;
    clear_mon();
    for (int k = 31; k < 60; k++) drive(1'b1, pat(k, cur_seed), 1'b0);
    fcs_ok = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    fcs_ok = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
    check("mid_tail_beats", beat_cnt, 0);
    check("mid_tail_pulse", pulse_cnt, 0);

    cur_seed = 78;
    clear_mon();
    send_frame(7, 8'hD5, 64, -1, 1'b1);
    check("after_reset_beats",    beat_cnt,  60);
    check("after_reset_data",     data_err,  0);
    check("after_reset_last_idx", last_idx,  59);
    check("after_reset_user",     last_user, 0);
    check("after_reset_pulse",    pulse_cnt, 1);
`ifdef ETH_RX_FRAMER_STATS_EN
    check("stat_ok_after_reset",    int'(stat_frames_ok),  1);
    check("stat_bad_after_reset",   int'(stat_frames_bad), 0);
    check("stat_runts_after_reset", int'(stat_runts),      0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
